de2_115_sd_card_nios_cpu_ocimem: RTL and testbench

DE2_115_SD_CARD_NIOS_CPU_OCIMEM -- requirements
Module: de2_115_sd_card_nios_cpu_ocimem

---
 rtl/de2_115_sd_card_nios_cpu_ocimem.sv | 169 ++++++++++++++++
 tb/tb_de2_115_sd_card_nios_cpu_ocimem.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_sd_card_nios_cpu_ocimem.sv
`default_nettype none
// ============================================================================
// Module   : de2_115_sd_card_nios_cpu_ocimem
// Purpose  : On-chip debug memory. A 256x32 RAM shared between the JTAG debug
//            path (take_* strobes carrying a jdo word) and a CPU slave port.
//            JTAG owns arbitration; CPU accesses stall while JTAG is active.
// Revision : 1.0 - initial release
// ============================================================================
module de2_115_sd_card_nios_cpu_ocimem (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [7:0]  cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_readdatavalid,
    output logic        cpu_waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    // State encoding: only c_IDLE accepts new JTAG or CPU requests
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_JRD  = 2'd1;
    localparam logic [1:0] c_JWR  = 2'd2;
    localparam logic [1:0] c_CRD  = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_jaddr;
    logic [31:0] r_mon_dreg;
    logic        r_monitor_ready;
    logic        r_monitor_error;
    logic [31:0] r_cpu_readdata;
    logic        r_cpu_readdatavalid;

    // Shared RAM; contents intentionally not reset
    logic [31:0] r_mem [0:255];

    logic        w_busy;
    logic        w_any_take;
    logic        w_multi_take;
    logic        w_accept_a;
    logic        w_accept_b;
    logic        w_accept_na;
    logic        w_err_set;
    logic        w_err_clr;
    logic        w_cpu_wr;
    logic        w_cpu_rd;
    logic        w_mem_we;
    logic [7:0]  w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_mem_rdata;
    logic        w_unused_jdo;

    // Bits of jdo that carry no meaning for this block
    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign w_busy       = (r_state != c_IDLE);
    assign w_any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_multi_take = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                        | (take_action_ocimem_b & take_no_action_ocimem_a);

    // Fixed priority among simultaneous strobes: a > b > no_action_a
    assign w_accept_a  = ~reset & ~w_busy & take_action_ocimem_a;
    assign w_accept_b  = ~reset & ~w_busy & take_action_ocimem_b & ~take_action_ocimem_a;
    assign w_accept_na = ~reset & ~w_busy & take_no_action_ocimem_a
                       & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // Dropped strobes (busy or lost priority) raise the sticky error
    assign w_err_set = (w_busy & w_any_take) | (~w_busy & w_multi_take);
    assign w_err_clr = w_accept_a & jdo[25];

    // JTAG always wins: any strobe, an op in flight or reset stalls the CPU
    assign cpu_waitrequest = reset | w_busy | w_any_take;

    // Write has precedence when the CPU asserts both read and write
    assign w_cpu_wr = ~cpu_waitrequest & cpu_write;
    assign w_cpu_rd = ~cpu_waitrequest & cpu_read & ~cpu_write;

    // Single RAM port: JTAG uses jaddr, CPU uses its own address when idle
    assign w_mem_we    = ~reset & (w_accept_b | w_cpu_wr);
    assign w_mem_addr  = (w_busy | w_accept_b) ? r_jaddr : cpu_address;
    assign w_mem_wdata = w_accept_b ? jdo[34:3] : cpu_writedata;
    assign w_mem_rdata = r_mem[w_mem_addr];

    // RAM write port
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Control FSM; MonDReg and cpu_readdata act as the RAM read registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= c_IDLE;
            r_jaddr             <= 8'd0;
            r_mon_dreg          <= 32'd0;
            r_monitor_ready     <= 1'b0;
            r_cpu_readdata      <= 32'd0;
            r_cpu_readdatavalid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cpu_readdatavalid <= 1'b0;
                    if (w_accept_a) begin
                        r_jaddr <= jdo[17:10];
                        if (jdo[35]) begin
                            r_monitor_ready <= 1'b0;
                            r_state         <= c_JRD;
                        end else begin
                            r_monitor_ready <= 1'b1;
                        end
                    end else if (w_accept_b) begin
                        r_monitor_ready <= 1'b0;
                        r_state         <= c_JWR;
                    end else if (w_accept_na) begin
                        r_monitor_ready <= 1'b0;
                        r_state         <= c_JRD;
                    end else if (w_cpu_rd) begin
                        r_cpu_readdata      <= w_mem_rdata;
                        r_cpu_readdatavalid <= 1'b1;
                        r_state             <= c_CRD;
                    end
                end
                c_JRD: begin
                    r_mon_dreg      <= w_mem_rdata;
                    r_monitor_ready <= 1'b1;
                    r_jaddr         <= r_jaddr + 8'd1;
                    r_state         <= c_IDLE;
                end
                c_JWR: begin
                    r_monitor_ready <= 1'b1;
                    r_jaddr         <= r_jaddr + 8'd1;
                    r_state         <= c_IDLE;
                end
                default: begin
                    r_cpu_readdatavalid <= 1'b0;
                    r_state             <= c_IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error; a new error outranks a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_monitor_error <= 1'b0;
        end else if (w_err_set) begin
            r_monitor_error <= 1'b1;
        end else if (w_err_clr) begin
            r_monitor_error <= 1'b0;
        end
    end

    assign MonDReg           = r_mon_dreg;
    assign monitor_ready     = r_monitor_ready;
    assign monitor_error     = r_monitor_error;
    assign cpu_readdata      = r_cpu_readdata;
    assign cpu_readdatavalid = r_cpu_readdatavalid;

endmodule
`default_nettype wire

// File: tb/tb_de2_115_sd_card_nios_cpu_ocimem.sv
`default_nettype none
// ============================================================================
// Module   : tb_de2_115_sd_card_nios_cpu_ocimem
// Purpose  : Self-checking bench: directed vector table, multi-cycle corner
//            sequences and randomized transactions against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de2_115_sd_card_nios_cpu_ocimem;

    localparam int OP_CW  = 0;  // CPU write
    localparam int OP_CR  = 1;  // CPU read
    localparam int OP_A   = 2;  // take_action_ocimem_a
    localparam int OP_B   = 3;  // take_action_ocimem_b
    localparam int OP_NA  = 4;  // take_no_action_ocimem_a
    localparam int OP_BNA = 5;  // b + no_action together
    localparam int OP_ANA = 6;  // a + no_action together
    localparam int OP_AB  = 7;  // a + b together

    typedef struct {
        int          op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rd;
        logic        clr;
        logic [31:0] exp_mon;
        logic        exp_ready;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic        cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference model
    logic [31:0] m_mem [0:255];
    logic [7:0]  m_jaddr;
    logic [31:0] m_mon;
    logic        m_ready;
    logic        m_err;

    de2_115_sd_card_nios_cpu_ocimem dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [7:0] addr, input logic [31:0] data,
                                input logic rd, input logic clr, input logic [31:0] mon,
                                input logic ready, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.rd = rd; v.clr = clr;
        v.exp_mon = mon; v.exp_ready = ready; v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    function automatic logic is_atype(input int op);
        return (op == OP_A) || (op == OP_ANA) || (op == OP_AB);
    endfunction

    function automatic logic [37:0] build_jdo(input vec_t v);
        logic [37:0] j;
        j = {6'($urandom_range(0, 63)), 32'($urandom)};
        if (is_atype(v.op)) begin
            j[35]    = v.rd;
            j[25]    = v.clr;
            j[17:10] = v.addr;
        end else begin
            j[34:3]  = v.data;
        end
        return j;
    endfunction

    // Model: what the debug memory should look like after one transaction
    task automatic model(inout vec_t v);
        if (is_atype(v.op)) begin
            m_jaddr = v.addr;
            if (v.clr) m_err = 1'b0;
            if (v.rd) begin
                m_mon   = m_mem[m_jaddr];
                m_jaddr = m_jaddr + 8'd1;
            end
            m_ready = 1'b1;
        end else if (v.op == OP_B || v.op == OP_BNA) begin
            m_mem[m_jaddr] = v.data;
            m_jaddr = m_jaddr + 8'd1;
            m_ready = 1'b1;
        end else if (v.op == OP_NA) begin
            m_mon   = m_mem[m_jaddr];
            m_jaddr = m_jaddr + 8'd1;
            m_ready = 1'b1;
        end else if (v.op == OP_CW) begin
            m_mem[v.addr] = v.data;
        end else begin
            v.exp_rdata = m_mem[v.addr];
        end
        if (v.op == OP_BNA || v.op == OP_ANA || v.op == OP_AB) m_err = 1'b1;
        v.exp_mon   = m_mon;
        v.exp_ready = m_ready;
        v.exp_err   = m_err;
    endtask

    task automatic model_reset();
        m_jaddr = 8'd0; m_mon = 32'd0; m_ready = 1'b0; m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        cpu_read                = 1'b0;
        cpu_write               = 1'b0;
    endtask

    // Drive one transaction in an idle cycle N, check N+1 and N+2
    task automatic apply(input vec_t v);
        logic atype;
        logic busy;
        logic cpu_op;
        atype  = is_atype(v.op);
        cpu_op = (v.op == OP_CW) || (v.op == OP_CR);
        busy   = (v.op == OP_B) || (v.op == OP_NA) || (v.op == OP_BNA) || (atype && v.rd);
        jdo                     = build_jdo(v);
        take_action_ocimem_a    = atype;
        take_action_ocimem_b    = (v.op == OP_B) || (v.op == OP_BNA) || (v.op == OP_AB);
        take_no_action_ocimem_a = (v.op == OP_NA) || (v.op == OP_BNA) || (v.op == OP_ANA);
        cpu_write               = (v.op == OP_CW);
        cpu_read                = (v.op == OP_CR);
        cpu_address             = v.addr;
        cpu_writedata           = v.data;
        #1;
        chk("waitreq_accept", {31'd0, cpu_waitrequest}, {31'd0, ~cpu_op});
        @(posedge clk); #1;
        idle_inputs();
        if (busy) begin
            chk("ready_busy", {31'd0, monitor_ready}, 32'd0);
            chk("waitreq_busy", {31'd0, cpu_waitrequest}, 32'd1);
        end
        if (atype && !v.rd) chk("ready_addr_only", {31'd0, monitor_ready}, 32'd1);
        if (v.op == OP_CR) begin
            chk("rdvalid", {31'd0, cpu_readdatavalid}, 32'd1);
            chk("readdata", cpu_readdata, v.exp_rdata);
        end
        @(posedge clk); #1;
        chk("MonDReg", MonDReg, v.exp_mon);
        chk("ready", {31'd0, monitor_ready}, {31'd0, v.exp_ready});
        chk("error", {31'd0, monitor_error}, {31'd0, v.exp_err});
        chk("rdvalid_pulse", {31'd0, cpu_readdatavalid}, 32'd0);
        chk("waitreq_idle", {31'd0, cpu_waitrequest}, 32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl [$];
    vec_t rv;
    int   k;

    initial begin
        jdo = 38'd0; cpu_address = 8'd0; cpu_writedata = 32'd0;
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_MonDReg", MonDReg, 32'd0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        chk("rst_readdata", cpu_readdata, 32'd0);
        chk("rst_rdvalid", {31'd0, cpu_readdatavalid}, 32'd0);
        reset = 1'b0;

        // Directed table: {op, addr, data, rd, clr, exp MonDReg, ready, error, readdata}
        tbl.push_back(mk(OP_CW,  8'h10, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(OP_A,   8'h10, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(OP_NA,  8'h00, 32'h0,        0, 0, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(OP_A,   8'hFE, 32'h0,        0, 0, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(OP_B,   8'h00, 32'hA5A5A5A5, 0, 0, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(OP_B,   8'h00, 32'h00000001, 0, 0, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(OP_B,   8'h00, 32'h00000002, 0, 0, 32'h12345678, 1, 0, 32'h0));
        tbl.push_back(mk(OP_CR,  8'h00, 32'h0,        0, 0, 32'h12345678, 1, 0, 32'h00000002));
        tbl.push_back(mk(OP_CR,  8'hFF, 32'h0,        0, 0, 32'h12345678, 1, 0, 32'h00000001));
        tbl.push_back(mk(OP_CR,  8'hFE, 32'h0,        0, 0, 32'h12345678, 1, 0, 32'hA5A5A5A5));
        tbl.push_back(mk(OP_A,   8'hFE, 32'h0,        1, 0, 32'hA5A5A5A5, 1, 0, 32'h0));
        tbl.push_back(mk(OP_NA,  8'h00, 32'h0,        0, 0, 32'h00000001, 1, 0, 32'h0));
        tbl.push_back(mk(OP_BNA, 8'h00, 32'hDEADBEEF, 0, 0, 32'h00000001, 1, 1, 32'h0));
        tbl.push_back(mk(OP_CR,  8'h00, 32'h0,        0, 0, 32'h00000001, 1, 1, 32'hDEADBEEF));
        tbl.push_back(mk(OP_A,   8'h20, 32'h0,        0, 1, 32'h00000001, 1, 0, 32'h0));
        tbl.push_back(mk(OP_ANA, 8'h00, 32'h0,        1, 1, 32'hDEADBEEF, 1, 1, 32'h0));
        tbl.push_back(mk(OP_AB,  8'hFE, 32'h0,        0, 0, 32'hDEADBEEF, 1, 1, 32'h0));
        tbl.push_back(mk(OP_NA,  8'h00, 32'h0,        0, 0, 32'hA5A5A5A5, 1, 1, 32'h0));
        foreach (tbl[i]) apply(tbl[i]);

        // CPU read of 0xFF held while a JTAG read of 0x10 wins arbitration
        jdo = 38'd0; jdo[35] = 1'b1; jdo[17:10] = 8'h10;
        take_action_ocimem_a = 1'b1;
        cpu_read = 1'b1; cpu_address = 8'hFF;
        #1;
        chk("arb_waitreq_strobe", {31'd0, cpu_waitrequest}, 32'd1);
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        chk("arb_waitreq_jrd", {31'd0, cpu_waitrequest}, 32'd1);
        chk("arb_no_rdvalid", {31'd0, cpu_readdatavalid}, 32'd0);
        k = 0;
        while (cpu_waitrequest && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("arb_wait_cycles", k, 32'd1);
        chk("arb_jtag_MonDReg", MonDReg, 32'h12345678);
        chk("arb_jtag_ready", {31'd0, monitor_ready}, 32'd1);
        @(posedge clk); #1;
        cpu_read = 1'b0;
        chk("arb_rdvalid", {31'd0, cpu_readdatavalid}, 32'd1);
        chk("arb_readdata", cpu_readdata, 32'h00000001);
        @(posedge clk); #1;
        chk("arb_rdvalid_end", {31'd0, cpu_readdatavalid}, 32'd0);

        // Strobe arriving mid-read is dropped and flags an error
        apply(mk(OP_A, 8'hFF, 32'h0, 0, 1, 32'h12345678, 1, 0, 32'h0));
        jdo = 38'd0;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        jdo[34:3] = 32'h55555555;
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        chk("busy_MonDReg", MonDReg, 32'h00000001);
        chk("busy_ready", {31'd0, monitor_ready}, 32'd1);
        chk("busy_error", {31'd0, monitor_error}, 32'd1);
        @(posedge clk); #1;
        apply(mk(OP_CR, 8'h00, 32'h0, 0, 0, 32'h00000001, 1, 1, 32'hDEADBEEF));

        // Randomized traffic against the model, memory fully initialised first
        do_reset();
        for (int a = 0; a < 256; a++) begin
            rv = mk(OP_CW, 8'(a), $urandom, 0, 0, 0, 0, 0, 0);
            model(rv);
            apply(rv);
        end
        for (int t = 0; t < 400; t++) begin
            int r;
            r = int'($urandom_range(0, 11));
            rv = mk(OP_CW, 8'($urandom_range(0, 255)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 0, 0, 0, 0);
            case (r)
                0, 1:    rv.op = OP_CW;
                2, 3:    rv.op = OP_CR;
                4, 5:    rv.op = OP_A;
                6, 7:    rv.op = OP_B;
                8, 9:    rv.op = OP_NA;
                10:      rv.op = OP_BNA;
                default: rv.op = ($urandom_range(0, 1) == 0) ? OP_ANA : OP_AB;
            endcase
            model(rv);
            apply(rv);
        end

        // Reset during a JTAG read aborts it; strobes under reset are ignored
        jdo = 38'd0;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        reset = 1'b1;
        jdo[34:3] = ~m_mem[0];
        take_action_ocimem_b = 1'b1;
        #1;
        chk("mid_rst_MonDReg", MonDReg, 32'd0);
        chk("mid_rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("mid_rst_error", {31'd0, monitor_error}, 32'd0);
        chk("mid_rst_readdata", cpu_readdata, 32'd0);
        chk("mid_rst_rdvalid", {31'd0, cpu_readdatavalid}, 32'd0);
        chk("mid_rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        take_action_ocimem_b = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        chk("post_rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
        rv = mk(OP_NA, 8'h00, 32'h0, 0, 0, 0, 0, 0, 0);
        model(rv);
        apply(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
